conv_encoder_stream: RTL and testbench

Parametrised streaming convolutional encoder for the transmit path. It replaces the fixed K/rate encoder with a runtime-configurable one: constraint length 3..K_MAX, rate 1/n for n in 1..N_MAX, and a selectable frame termination mode. It accepts one information bit per cycle over a valid/ready handshake and emits one n-bit code symbol per cycle over a registered valid/ready output with a frame-last marker. It sits between the bit source and the modulator/interleaver, and per-frame configuration comes from the control block.

---
 rtl/conv_encoder_stream.sv | 187 ++++++++++++++++++
 tb/tb_conv_encoder_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_stream.sv
// Runtime-configurable rate-1/n convolutional encoder. Takes one information bit per cycle over
// valid/ready and emits one registered n-bit symbol per cycle, with optional zero-tail termination.
module conv_encoder_stream #(
  parameter int unsigned K_MAX = 9,
  parameter int unsigned N_MAX = 3,
  parameter int unsigned LEN_W = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MAX*K_MAX-1:0]       i_gen_poly,
  input  logic [$clog2(K_MAX+1)-1:0]   i_k,
  input  logic [$clog2(N_MAX+1)-1:0]   i_n,
  input  logic                         i_term,
  input  logic [LEN_W-1:0]             i_frame_len,
  input  logic                         i_start,
  input  logic                         i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [N_MAX-1:0]             o_sym,
  output logic [N_MAX-1:0]             o_sym_mask,
  output logic                         o_sym_valid,
  input  logic                         i_sym_ready,
  output logic                         o_sym_last,
  output logic                         o_busy,
  output logic                         o_cfg_err
);

  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned NW = $clog2(N_MAX + 1);
  localparam int unsigned PW = N_MAX * K_MAX;

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e           state_q, state_d;
  logic [K_MAX-2:0] sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [KW-1:0]    tcnt_q, tcnt_d, k_q, k_d;
  logic [NW-1:0]    n_q, n_d;
  logic             term_q, term_d;
  logic [PW-1:0]    poly_q, poly_d;
  logic [N_MAX-1:0] sym_q, sym_d, mask_q, mask_d;
  logic             vld_q, vld_d, last_q, last_d, err_q, err_d;

  logic             slot_free, cfg_ok, enc_bit, produce, prod_last;
  logic [K_MAX-1:0] mux, kmask;
  logic [N_MAX-1:0] sym_new, new_mask;

  assign slot_free = !vld_q || i_sym_ready;
  assign cfg_ok    = (i_k >= KW'(3)) && (i_k <= KW'(K_MAX)) && (i_n != '0) &&
                     (i_n <= NW'(N_MAX)) && (i_frame_len != '0);
  // Tail cycles feed zeros through the same encoder path as data.
  assign enc_bit   = (state_q == StData) ? i_data : 1'b0;

  always_comb begin
    mux   = {sr_q, enc_bit};
    kmask = '0;
    for (int j = 0; j < K_MAX; j++) kmask[j] = (j < int'(k_q));
    sym_new  = '0;
    new_mask = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < int'(n_q)) sym_new[i] = ^(mux & poly_q[i*K_MAX +: K_MAX] & kmask);
      new_mask[i] = (i < int'(i_n));
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    k_d       = k_q;
    n_d       = n_q;
    term_d    = term_q;
    len_d     = len_q;
    poly_d    = poly_q;
    mask_d    = mask_q;
    err_d     = err_q;
    sym_d     = sym_q;
    vld_d     = vld_q;
    last_d    = last_q;
    o_ready   = 1'b0;
    produce   = 1'b0;
    prod_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (cfg_ok) begin
            k_d     = i_k;
            n_d     = i_n;
            term_d  = i_term;
            len_d   = i_frame_len;
            poly_d  = i_gen_poly;
            mask_d  = new_mask;
            sr_d    = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
            err_d   = 1'b0;
            state_d = StData;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        o_ready = slot_free;
        if (i_valid && slot_free) begin
          produce = 1'b1;
          sr_d    = {sr_q[K_MAX-3:0], enc_bit};
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            if (term_q) begin
              tcnt_d  = '0;
              state_d = StTail;
            end else begin
              prod_last = 1'b1;
              state_d   = StIdle;
            end
          end
        end
      end
      StTail: begin
        if (slot_free) begin
          produce = 1'b1;
          sr_d    = {sr_q[K_MAX-3:0], enc_bit};
          tcnt_d  = tcnt_q + KW'(1);
          if (tcnt_d == k_q - KW'(1)) begin
            prod_last = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (produce) begin
      sym_d  = sym_new;
      vld_d  = 1'b1;
      last_d = prod_last;
    end else if (i_sym_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      term_q  <= 1'b0;
      len_q   <= '0;
      poly_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      term_q  <= term_d;
      len_q   <= len_d;
      poly_q  <= poly_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign o_sym       = sym_q;
  assign o_sym_mask  = mask_q;
  assign o_sym_valid = vld_q;
  assign o_sym_last  = last_q;
  assign o_cfg_err   = err_q;
  assign o_busy      = (state_q != StIdle) || vld_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Self-checking bench for conv_encoder_stream: directed frames plus randomized frames compared
// against a direct convolution-sum reference model.
`timescale 1ns/1ps
module tb_conv_encoder_stream;

  localparam int K_MAX = 9;
  localparam int N_MAX = 3;
  localparam int LEN_W = 12;
  localparam int PW    = N_MAX * K_MAX;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int NW    = $clog2(N_MAX + 1);
  localparam logic [PW-1:0] PolyK3 = {9'd0, 9'b000000101, 9'b000000111};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PW-1:0]    i_gen_poly = '0;
  logic [KW-1:0]    i_k = '0;
  logic [NW-1:0]    i_n = '0;
  logic             i_term = 1'b0;
  logic [LEN_W-1:0] i_frame_len = '0;
  logic             i_start = 1'b0;
  logic             i_data = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_sym_ready = 1'b0;
  logic             o_ready, o_sym_valid, o_sym_last, o_busy, o_cfg_err;
  logic [N_MAX-1:0] o_sym, o_sym_mask;

  conv_encoder_stream #(.K_MAX(K_MAX), .N_MAX(N_MAX), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_gen_poly(i_gen_poly), .i_k(i_k), .i_n(i_n), .i_term(i_term),
    .i_frame_len(i_frame_len), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_sym(o_sym), .o_sym_mask(o_sym_mask), .o_sym_valid(o_sym_valid),
    .i_sym_ready(i_sym_ready), .o_sym_last(o_sym_last), .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  int               nchecks = 0;
  int               nerrors = 0;
  bit               data_bits [64];
  logic [N_MAX-1:0] cap_sym [$];
  bit               cap_last [$];
  logic [N_MAX-1:0] exp_sym [$];
  logic [N_MAX-1:0] basic_exp [6] = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3};
  bit               timeout;
  int               stall_bad, stall_seen;
  logic             first_ready;

  // Reference: symbol t, output i = XOR over d<k of poly_i[d] * b[t-d], tail bits are zero.
  task automatic build_model(input int k, input int n, input logic [PW-1:0] poly,
                             input bit term, input int len);
    int total;
    logic [N_MAX-1:0] s;
    total = len + (term ? k - 1 : 0);
    exp_sym.delete();
    for (int t = 0; t < total; t++) begin
      s = '0;
      for (int i = 0; i < n; i++)
        for (int d = 0; d < k && d <= t; d++)
          if (t - d < len) s[i] = s[i] ^ (poly[i*K_MAX + d] & data_bits[t - d]);
      exp_sym.push_back(s);
    end
  endtask

  task automatic set_basic_bits();
    data_bits[0] = 1'b1; data_bits[1] = 1'b0; data_bits[2] = 1'b1; data_bits[3] = 1'b1;
  endtask

  // Starts a frame and collects handshaked symbols until the last one (or abort/timeout).
  task automatic run_frame(input int k, input int n, input logic [PW-1:0] poly, input bit term,
                           input int len, input bit rdy_rand, input bit vld_rand,
                           input int stall_at, input int abort_at);
    int bit_idx, cyc, nsym, stall_left;
    bit done;
    logic [N_MAX-1:0] held_sym;
    logic held_last;
    bit_idx = 0; cyc = 0; nsym = 0; stall_left = 0; done = 0;
    held_sym = '0; held_last = 1'b0;
    cap_sym.delete(); cap_last.delete();
    timeout = 0; stall_bad = 0; stall_seen = 0; first_ready = 1'b0;
    @(negedge clk);
    i_k = KW'(k); i_n = NW'(n); i_gen_poly = poly; i_term = term;
    i_frame_len = LEN_W'(len); i_start = 1'b1; i_valid = 1'b0; i_sym_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (!done) begin
      if (cyc >= 3000) begin
        timeout = 1;
        break;
      end
      if (stall_left > 0) i_sym_ready = 1'b0;
      else i_sym_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_valid = (bit_idx < len) && (vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      i_data  = (bit_idx < len) ? data_bits[bit_idx] : 1'b0;
      #1;
      if (cyc == 0) first_ready = o_ready;
      if (stall_left > 0) begin
        if (stall_left == 3) begin
          held_sym = o_sym; held_last = o_sym_last;
        end
        if (!o_sym_valid || o_ready || o_sym !== held_sym || o_sym_last !== held_last)
          stall_bad++;
        stall_seen++;
        stall_left--;
      end
      if (o_sym_valid && i_sym_ready) begin
        cap_sym.push_back(o_sym);
        cap_last.push_back(o_sym_last);
        nsym++;
        if (o_sym_last) done = 1;
        if (nsym == stall_at) stall_left = 3;
      end
      if (i_valid && o_ready) bit_idx++;
      if (abort_at >= 0 && bit_idx == abort_at) break;
      cyc++;
      if (!done) @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_sym_ready = 1'b1;
    repeat (2) @(negedge clk);
    nchecks++;
    if ({o_ready, o_sym_valid, o_sym_last, o_busy, o_cfg_err, o_sym, o_sym_mask} !== '0) begin
      nerrors++;
      $display("FAIL reset_hold: got rdy=%b vld=%b last=%b busy=%b err=%b sym=%b mask=%b, want all 0",
               o_ready, o_sym_valid, o_sym_last, o_busy, o_cfg_err, o_sym, o_sym_mask);
    end
    rst = 1'b1;
    @(negedge clk);
    nchecks++;
    if ({o_ready, o_sym_valid, o_busy, o_cfg_err, o_sym_mask} !== '0) begin
      nerrors++;
      $display("FAIL reset_idle: got rdy=%b vld=%b busy=%b err=%b mask=%b, want all 0",
               o_ready, o_sym_valid, o_busy, o_cfg_err, o_sym_mask);
    end
  endtask

  task automatic test_basic();
    set_basic_bits();
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, -1);
    nchecks++;
    if (timeout || cap_sym.size() != 6) begin
      nerrors++;
      $display("FAIL basic_count: got %0d symbols (timeout=%0d), want 6", cap_sym.size(), timeout);
    end
    for (int j = 0; j < 6; j++) begin
      nchecks++;
      if (j >= cap_sym.size() || cap_sym[j] !== basic_exp[j] || cap_last[j] !== (j == 5)) begin
        nerrors++;
        $display("FAIL basic_sym%0d: got %b last=%b, want %b last=%b", j,
                 (j < cap_sym.size()) ? cap_sym[j] : 3'bxxx,
                 (j < cap_sym.size()) ? cap_last[j] : 1'b0, basic_exp[j], (j == 5));
      end
    end
    nchecks++;
    if (o_sym_mask !== 3'b011) begin
      nerrors++;
      $display("FAIL basic_mask: got %b, want 011", o_sym_mask);
    end
  endtask

  task automatic test_backpressure();
    set_basic_bits();
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 2, -1);
    nchecks++;
    if (stall_bad != 0 || stall_seen != 3) begin
      nerrors++;
      $display("FAIL stall_hold: got %0d bad of %0d stall cycles, want 0 of 3", stall_bad, stall_seen);
    end
    for (int j = 0; j < 6; j++) begin
      nchecks++;
      if (j >= cap_sym.size() || cap_sym[j] !== basic_exp[j] || cap_last[j] !== (j == 5)) begin
        nerrors++;
        $display("FAIL stall_sym%0d: got %b, want %b (count %0d)", j,
                 (j < cap_sym.size()) ? cap_sym[j] : 3'bxxx, basic_exp[j], cap_sym.size());
      end
    end
  endtask

  task automatic test_k7();
    logic [PW-1:0] poly;
    poly = '0;
    poly[0 +: 7] = 7'o133; poly[9 +: 7] = 7'o171; poly[18 +: 7] = 7'o165;
    for (int t = 0; t < 24; t++) data_bits[t] = 1'($urandom);
    build_model(7, 3, poly, 1'b0, 24);
    run_frame(7, 3, poly, 1'b0, 24, 1'b0, 1'b0, 0, -1);
    nchecks++;
    if (timeout || cap_sym.size() != 24) begin
      nerrors++;
      $display("FAIL k7_count: got %0d symbols (timeout=%0d), want 24", cap_sym.size(), timeout);
    end
    for (int j = 0; j < 24 && j < cap_sym.size(); j++) begin
      nchecks++;
      if (cap_sym[j] !== exp_sym[j] || cap_last[j] !== (j == 23)) begin
        nerrors++;
        $display("FAIL k7_sym%0d: got %b last=%b, want %b last=%b", j, cap_sym[j], cap_last[j],
                 exp_sym[j], (j == 23));
      end
    end
    nchecks++;
    if (o_sym_mask !== 3'b111) begin
      nerrors++;
      $display("FAIL k7_mask: got %b, want 111", o_sym_mask);
    end
  endtask

  task automatic test_cfg_err();
    @(negedge clk);
    i_k = KW'(2); i_n = NW'(2); i_frame_len = LEN_W'(4); i_term = 1'b1; i_start = 1'b1;
    i_sym_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    nchecks++;
    if (o_cfg_err !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
      nerrors++;
      $display("FAIL cfg_err_set: got err=%b busy=%b rdy=%b, want 1 0 0", o_cfg_err, o_busy, o_ready);
    end
    set_basic_bits();
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, -1);
    nchecks++;
    if (o_cfg_err !== 1'b0) begin
      nerrors++;
      $display("FAIL cfg_err_clear: got %b, want 0", o_cfg_err);
    end
    for (int j = 0; j < 6; j++) begin
      nchecks++;
      if (j >= cap_sym.size() || cap_sym[j] !== basic_exp[j] || cap_last[j] !== (j == 5)) begin
        nerrors++;
        $display("FAIL cfg_sym%0d: got %b, want %b (count %0d)", j,
                 (j < cap_sym.size()) ? cap_sym[j] : 3'bxxx, basic_exp[j], cap_sym.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    set_basic_bits();
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchecks++;
    if ({o_ready, o_sym_valid, o_sym_last, o_busy, o_cfg_err, o_sym, o_sym_mask} !== '0) begin
      nerrors++;
      $display("FAIL midreset_clear: got rdy=%b vld=%b busy=%b sym=%b mask=%b, want all 0",
               o_ready, o_sym_valid, o_busy, o_sym, o_sym_mask);
    end
    rst = 1'b1;
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, -1);
    for (int j = 0; j < 6; j++) begin
      nchecks++;
      if (j >= cap_sym.size() || cap_sym[j] !== basic_exp[j] || cap_last[j] !== (j == 5)) begin
        nerrors++;
        $display("FAIL midreset_sym%0d: got %b, want %b (count %0d)", j,
                 (j < cap_sym.size()) ? cap_sym[j] : 3'bxxx, basic_exp[j], cap_sym.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    set_basic_bits();
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, -1);
    run_frame(3, 2, PolyK3, 1'b1, 4, 1'b0, 1'b0, 0, -1);
    nchecks++;
    if (first_ready !== 1'b1) begin
      nerrors++;
      $display("FAIL b2b_ready: got o_ready=%b in first cycle after start, want 1", first_ready);
    end
    for (int j = 0; j < 6; j++) begin
      nchecks++;
      if (j >= cap_sym.size() || cap_sym[j] !== basic_exp[j] || cap_last[j] !== (j == 5)) begin
        nerrors++;
        $display("FAIL b2b_sym%0d: got %b, want %b (count %0d)", j,
                 (j < cap_sym.size()) ? cap_sym[j] : 3'bxxx, basic_exp[j], cap_sym.size());
      end
    end
  endtask

  task automatic test_random();
    int k, n, len;
    bit term;
    logic [PW-1:0] poly;
    for (int f = 0; f < 8; f++) begin
      k = $urandom_range(3, K_MAX);
      n = $urandom_range(1, N_MAX);
      len = $urandom_range(1, 40);
      term = 1'($urandom);
      poly = PW'($urandom);
      for (int t = 0; t < len; t++) data_bits[t] = 1'($urandom);
      build_model(k, n, poly, term, len);
      run_frame(k, n, poly, term, len, 1'b1, 1'b1, 0, -1);
      nchecks++;
      if (timeout || cap_sym.size() != exp_sym.size()) begin
        nerrors++;
        $display("FAIL rand%0d_count: got %0d symbols (timeout=%0d), want %0d (k=%0d n=%0d term=%0d len=%0d)",
                 f, cap_sym.size(), timeout, exp_sym.size(), k, n, term, len);
      end
      for (int j = 0; j < exp_sym.size() && j < cap_sym.size(); j++) begin
        nchecks++;
        if (cap_sym[j] !== exp_sym[j] || cap_last[j] !== (j == exp_sym.size() - 1)) begin
          nerrors++;
          $display("FAIL rand%0d_sym%0d: got %b last=%b, want %b last=%b", f, j, cap_sym[j],
                   cap_last[j], exp_sym[j], (j == exp_sym.size() - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_k7();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
